// File: rtl/br_pred_pkg.sv
// br_pred_pkg: shared definitions for the branch resolution / prediction unit.
//   - BR_* opcode encodings carried on ex_br_op
//   - 2-bit saturating counter constants and helpers used by the BTB
package br_pred_pkg;

  // Branch / jump operation encodings (3-bit ex_br_op)
  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd2;
  localparam logic [2:0] BR_BLTU = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BGEU = 3'd5;
  localparam logic [2:0] BR_JAL  = 3'd6;
  localparam logic [2:0] BR_JALR = 3'd7;

  // Counter value on allocation: branches start weakly taken, jumps strongly taken
  localparam logic [1:0] CNT_WEAK_TAKEN   = 2'b10;
  localparam logic [1:0] CNT_STRONG_TAKEN = 2'b11;

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/br_pred_cmp.sv
// br_cmp: stateless branch resolution path.
//   live_i      instruction is a live branch/jump (gates taken_o)
//   op_i        BR_* operation
//   pc_i, imm_i, rs1_i, rs2_i  PC, immediate and operands
//   taken_o     actual outcome
//   new_pc_o    architecturally correct next PC
//   pc_plus4_o  pc_i + 4
module br_cmp
  import br_pred_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            live_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o,
  output logic [XLEN-1:0] new_pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic            cond;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] tgt;

  // Direct magnitude compares; no subtract-and-inspect-sign tricks.
  always_comb begin
    cond = 1'b0;
    case (op_i)
      BR_BEQ:  cond = (rs1_i == rs2_i);
      BR_BNE:  cond = (rs1_i != rs2_i);
      BR_BLT:  cond = ($signed(rs1_i) <  $signed(rs2_i));
      BR_BLTU: cond = (rs1_i <  rs2_i);
      BR_BGE:  cond = ($signed(rs1_i) >= $signed(rs2_i));
      BR_BGEU: cond = (rs1_i >= rs2_i);
      BR_JAL:  cond = 1'b1;
      BR_JALR: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign pc_plus4_o = pc_i + XLEN'(4);
  assign br_tgt     = pc_i + imm_i;
  assign jalr_sum   = rs1_i + imm_i;
  // JALR clears bit 0 of the computed address
  assign tgt        = (op_i == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : br_tgt;
  assign taken_o    = live_i & cond;
  assign new_pc_o   = taken_o ? tgt : pc_plus4_o;

endmodule

// File: rtl/br_pred.sv
// br_pred: branch resolution, mispredict detection, direct-mapped BTB with
// 2-bit counters, and branch / mispredict performance counters.
//   clk, rst                 clock, async active-high reset
//   if_pc -> pred_hit, pred_taken, pred_target   fetch-side lookup
//   ex_*                     execute-side branch and its fetch-time prediction
//   ex_pc_plus4, ex_new_pc, ex_br_taken, mispredict, redirect_pc   resolution
//   tbl_flush                invalidate all BTB entries
//   br_count, mispred_count  performance counters (wrap at 2^32)
module br_pred
  import br_pred_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_br_sig,
  input  logic [2:0]      ex_br_op,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] ex_pc_plus4,
  output logic [XLEN-1:0] ex_new_pc,
  output logic            ex_br_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            tbl_flush,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // BTB state; lookup is combinational so the arrays are plain registers
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [1:0]         cnt_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];

  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  // ---------------- Resolution ----------------
  logic live;
  assign live = ex_valid & ex_br_sig;

  br_cmp #(.XLEN(XLEN)) u_cmp (
    .live_i     (live),
    .op_i       (ex_br_op),
    .pc_i       (ex_pc),
    .imm_i      (ex_imm),
    .rs1_i      (ex_rs1),
    .rs2_i      (ex_rs2),
    .taken_o    (ex_br_taken),
    .new_pc_o   (ex_new_pc),
    .pc_plus4_o (ex_pc_plus4)
  );

  // A non-branch predicted taken means fetch hit an aliased entry.
  logic alias_hit;
  assign alias_hit = ex_valid & ~ex_br_sig & ex_pred_taken;

  always_comb begin
    mispredict = 1'b0;
    if (live) begin
      mispredict = (ex_br_taken != ex_pred_taken) ||
                   (ex_br_taken && (ex_new_pc != ex_pred_target));
    end else if (alias_hit) begin
      mispredict = 1'b1;
    end
  end

  assign redirect_pc = ex_new_pc;

  // ---------------- Lookup ----------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];

  assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = pred_hit && (jump_q[if_idx] || cnt_q[if_idx][1]);
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(4);

  // ---------------- Update decode ----------------
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             is_jump;
  logic             upd_en, alias_en;
  logic             alloc_en, inc_en, dec_en;
  logic [ENTRIES-1:0] ent_sel;

  assign ex_idx   = ex_pc[IDX_W+1:2];
  assign ex_tag   = ex_pc[XLEN-1:IDX_W+2];
  assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign is_jump  = (ex_br_op == BR_JAL) || (ex_br_op == BR_JALR);
  assign upd_en   = live & ~ex_stall;
  assign alias_en = alias_hit & ~ex_stall;
  assign alloc_en = upd_en &  ex_br_taken & ~ex_hit;
  assign inc_en   = upd_en &  ex_br_taken &  ex_hit;
  assign dec_en   = upd_en & ~ex_br_taken &  ex_hit;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_sel
      assign ent_sel[gi] = (ex_idx == IDX_W'(gi));
    end
  endgenerate

  // Valid / counter / jump state: reset and flush apply here. Flush wins
  // over any same-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b00;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (tbl_flush) begin
          valid_q[i] <= 1'b0;
        end else if (ent_sel[i]) begin
          if (alloc_en) begin
            valid_q[i] <= 1'b1;
            jump_q[i]  <= is_jump;
            cnt_q[i]   <= is_jump ? CNT_STRONG_TAKEN : CNT_WEAK_TAKEN;
          end else if (inc_en) begin
            cnt_q[i]   <= cnt_inc(cnt_q[i]);
          end else if (dec_en) begin
            cnt_q[i]   <= cnt_dec(cnt_q[i]);
          end else if (alias_en) begin
            valid_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Tag / target payload: no reset needed, guarded by valid_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (!tbl_flush && ent_sel[i] && upd_en && ex_br_taken) begin
        tag_q[i] <= ex_tag;
        tgt_q[i] <= ex_new_pc;
      end
    end
  end

  // ---------------- Performance counters ----------------
  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_en) br_count_d = br_count_q + 32'd1;
    if ((upd_en || alias_en) && mispredict) mispred_count_d = mispred_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_br_pred.sv
// Bench for br_pred (ENTRIES=4 so aliasing on index 0 is easy to provoke).
module tb_br_pred;
  import br_pred_pkg::*;

  localparam int TB_ENTRIES = 4;
  localparam int TB_IDX_W   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = 32'h100;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0, ex_stall = 1'b0, ex_br_sig = 1'b0;
  logic [2:0]  ex_br_op = 3'd0;
  logic [31:0] ex_pc = 32'h0, ex_imm = 32'h0, ex_rs1 = 32'h0, ex_rs2 = 32'h0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = 32'h0;
  logic [31:0] ex_pc_plus4, ex_new_pc, redirect_pc;
  logic        ex_br_taken, mispredict;
  logic        tbl_flush = 1'b0;
  logic [31:0] br_count, mispred_count;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  br_pred #(.XLEN(32), .ENTRIES(TB_ENTRIES)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_br_sig(ex_br_sig),
    .ex_br_op(ex_br_op), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_pc_plus4(ex_pc_plus4), .ex_new_pc(ex_new_pc), .ex_br_taken(ex_br_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .tbl_flush(tbl_flush),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  logic        m_valid [TB_ENTRIES];
  logic        m_jump  [TB_ENTRIES];
  int          m_cnt   [TB_ENTRIES];
  logic [31:0] m_tag   [TB_ENTRIES];
  logic [31:0] m_tgt   [TB_ENTRIES];
  logic [31:0] m_br, m_mis;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % TB_ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc >> (2 + TB_IDX_W);
  endfunction

  function automatic logic f_live();
    return ex_valid && ex_br_sig;
  endfunction

  function automatic logic f_taken();
    logic t;
    t = 1'b0;
    if (ex_br_op == BR_BEQ)       t = (ex_rs1 == ex_rs2);
    else if (ex_br_op == BR_BNE)  t = (ex_rs1 != ex_rs2);
    else if (ex_br_op == BR_BLT)  t = ($signed(ex_rs1) <  $signed(ex_rs2));
    else if (ex_br_op == BR_BLTU) t = (ex_rs1 <  ex_rs2);
    else if (ex_br_op == BR_BGE)  t = ($signed(ex_rs1) >= $signed(ex_rs2));
    else if (ex_br_op == BR_BGEU) t = (ex_rs1 >= ex_rs2);
    else                          t = 1'b1;  // JAL / JALR
    return f_live() && t;
  endfunction

  function automatic logic [31:0] f_new_pc();
    if (!f_taken()) return ex_pc + 32'd4;
    if (ex_br_op == BR_JALR) return (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
    return ex_pc + ex_imm;
  endfunction

  function automatic logic f_mis();
    if (f_live())
      return (f_taken() != ex_pred_taken) ||
             (f_taken() && ex_pred_taken && f_new_pc() != ex_pred_target);
    return ex_valid && ex_pred_taken;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TB_ENTRIES; i++) begin
        m_valid[i] = 1'b0; m_jump[i] = 1'b0; m_cnt[i] = 0;
      end
      m_br = 32'd0; m_mis = 32'd0;
    end else if (!ex_stall) begin
      int  i;
      logic hit;
      i   = m_idx(ex_pc);
      hit = m_valid[i] && (m_tag[i] == m_tagof(ex_pc));
      if (f_live()) m_br = m_br + 32'd1;
      if ((f_live() || ex_valid) && f_mis()) m_mis = m_mis + 32'd1;
      if (tbl_flush) begin
        for (int k = 0; k < TB_ENTRIES; k++) m_valid[k] = 1'b0;
      end else if (f_live()) begin
        if (f_taken()) begin
          if (hit) begin
            m_tgt[i] = f_new_pc();
            m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          end else begin
            m_valid[i] = 1'b1;
            m_tag[i]   = m_tagof(ex_pc);
            m_tgt[i]   = f_new_pc();
            m_jump[i]  = (ex_br_op == BR_JAL) || (ex_br_op == BR_JALR);
            m_cnt[i]   = m_jump[i] ? 3 : 2;
          end
        end else if (hit) begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (ex_valid && ex_pred_taken) begin
        m_valid[i] = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int   i;
      logic hit, ptk;
      i   = m_idx(if_pc);
      hit = m_valid[i] && (m_tag[i] == m_tagof(if_pc));
      ptk = hit && (m_jump[i] || m_cnt[i] >= 2);
      chk("pred_hit",      {31'd0, pred_hit},    {31'd0, hit});
      chk("pred_taken",    {31'd0, pred_taken},  {31'd0, ptk});
      chk("pred_target",   pred_target,          ptk ? m_tgt[i] : if_pc + 32'd4);
      chk("ex_pc_plus4",   ex_pc_plus4,          ex_pc + 32'd4);
      chk("ex_new_pc",     ex_new_pc,            f_new_pc());
      chk("redirect_pc",   redirect_pc,          f_new_pc());
      chk("ex_br_taken",   {31'd0, ex_br_taken}, {31'd0, f_taken()});
      chk("mispredict",    {31'd0, mispredict},  {31'd0, f_mis()});
      chk("br_count",      br_count,             m_br);
      chk("mispred_count", mispred_count,        m_mis);
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_br_sig = 1'b0; ex_pred_taken = 1'b0; ex_stall = 1'b0; tbl_flush = 1'b0;
  endtask

  task automatic br(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic pt, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_br_sig = 1'b1; ex_br_op = op; ex_pc = pc; ex_imm = imm;
    ex_rs1 = a; ex_rs2 = b; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  logic [31:0] ops_a [4] = '{32'd5, 32'd3, 32'h8000_0000, 32'd7};
  logic [31:0] ops_b [4] = '{32'd5, 32'd7, 32'd1,          32'd3};
  logic [31:0] br_before;

  initial begin
    // Reset state
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("rst_pred_hit",    {31'd0, pred_hit}, 32'd0);
    chk("rst_pred_target", pred_target, 32'h104);
    chk("rst_br_count",    br_count, 32'd0);
    chk("rst_mispredict",  {31'd0, mispredict}, 32'd0);
    chk_en = 1'b1;

    // BEQ taken, predicted not taken
    step(); br(BR_BEQ, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 32'h0); #1;
    chk("beq_mispredict", {31'd0, mispredict}, 32'd1);
    chk("beq_redirect",   redirect_pc, 32'h140);
    step(); idle(); if_pc = 32'h100; #1;
    chk("beq_lookup_hit",    {31'd0, pred_hit}, 32'd1);
    chk("beq_lookup_taken",  {31'd0, pred_taken}, 32'd1);
    chk("beq_lookup_target", pred_target, 32'h140);
    chk("beq_br_count",      br_count, 32'd1);

    // BLT signed taken; BLTU with same operands not taken -> cnt 10 -> 01
    step(); br(BR_BLT, 32'h204, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0); #1;
    chk("blt_taken", {31'd0, ex_br_taken}, 32'd1);
    step(); br(BR_BLTU, 32'h204, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h224); #1;
    chk("bltu_taken",    {31'd0, ex_br_taken}, 32'd0);
    chk("bltu_redirect", redirect_pc, 32'h208);
    step(); idle(); if_pc = 32'h204; #1;
    chk("bltu_lookup_hit",   {31'd0, pred_hit}, 32'd1);
    chk("bltu_lookup_taken", {31'd0, pred_taken}, 32'd0);
    chk("bltu_lookup_tgt",   pred_target, 32'h208);
    chk("bltu_mis_count",    mispred_count, 32'd3);

    // JALR: allocate with target 0x2000, then re-resolve to 0x1006
    step(); br(BR_JALR, 32'h308, 32'd4, 32'h1FFC, 32'd0, 1'b0, 32'h0);
    step(); br(BR_JALR, 32'h308, 32'd4, 32'h1003, 32'd0, 1'b1, 32'h2000); #1;
    chk("jalr_new_pc",     ex_new_pc, 32'h1006);
    chk("jalr_mispredict", {31'd0, mispredict}, 32'd1);
    step(); idle(); if_pc = 32'h308; #1;
    chk("jalr_lookup_tgt", pred_target, 32'h1006);

    // Flush with a simultaneous update
    step(); br(BR_BEQ, 32'h30C, 32'd8, 32'd1, 32'd1, 1'b0, 32'h0); tbl_flush = 1'b1;
    step(); idle(); if_pc = 32'h308; #1;
    chk("flush_hit_308", {31'd0, pred_hit}, 32'd0);
    if_pc = 32'h30C; #1;
    chk("flush_hit_30c", {31'd0, pred_hit}, 32'd0);

    // Aliasing on index 0: 0x20 overwrites 0x10
    step(); br(BR_BEQ, 32'h10, 32'h10, 32'd0, 32'd0, 1'b0, 32'h0);
    step(); br(BR_BEQ, 32'h20, 32'h100, 32'd0, 32'd0, 1'b0, 32'h0);
    step(); idle(); if_pc = 32'h10; #1;
    chk("alias_hit_10", {31'd0, pred_hit}, 32'd0);
    if_pc = 32'h20; #1;
    chk("alias_tgt_20", pred_target, 32'h120);

    // Non-branch predicted taken: redirect to pc+4 and invalidate entry
    step(); ex_valid = 1'b1; ex_br_sig = 1'b0; ex_pc = 32'h20;
    ex_pred_taken = 1'b1; ex_pred_target = 32'h120; #1;
    chk("nb_mispredict", {31'd0, mispredict}, 32'd1);
    chk("nb_redirect",   redirect_pc, 32'h24);
    step(); idle(); if_pc = 32'h20; #1;
    chk("nb_invalidated", {31'd0, pred_hit}, 32'd0);

    // Stall held 3 cycles: exactly one count when it drops
    br_before = br_count;
    step(); br(BR_BEQ, 32'h40, 32'h8, 32'd2, 32'd2, 1'b0, 32'h0); ex_stall = 1'b1;
    step(); step(); step(); #1;
    chk("stall_no_count", br_count, br_before);
    ex_stall = 1'b0;
    step(); idle(); #1;
    chk("stall_one_count", br_count, br_before + 32'd1);

    // All operations over a small operand table
    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        br(3'(op), 32'h400 + 32'(op * 16) + 32'(k * 4), 32'h80, ops_a[k], ops_b[k],
           k[0], 32'h480 + 32'(op * 16) + 32'(k * 4));
        if_pc = 32'h400 + 32'(k * 4);
      end
    end
    step(); idle();

    // Asynchronous reset mid-sequence
    if_pc = 32'h40;
    step(); br(BR_BNE, 32'h40, 32'h8, 32'd1, 32'd2, 1'b0, 32'h0);
    #2 rst = 1'b1; #1;
    chk("midrst_br_count",  br_count, 32'd0);
    chk("midrst_mis_count", mispred_count, 32'd0);
    chk("midrst_pred_hit",  {31'd0, pred_hit}, 32'd0);
    @(negedge clk); #1 rst = 1'b0; idle();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
